// File: rtl/dm_port_arbiter_pkg.sv
// Shared data-memory access definitions: op size encodings, requester port
// indices and the alignment rule used by the MEM stage and the load extender.
package dm_port_arbiter_pkg;

    typedef enum logic [1:0] {
        OP_WORD = 2'b00,
        OP_BYTE = 2'b01,
        OP_HALF = 2'b10,
        OP_NONE = 2'b11
    } mem_op_e;

    localparam logic PORT_CPU = 1'b0;
    localparam logic PORT_DMA = 1'b1;

    function automatic logic is_misaligned(input mem_op_e op, input logic [1:0] addr_lo);
        logic mis;
        mis = 1'b0;
        case (op)
            OP_WORD: mis = (addr_lo != 2'b00);
            OP_HALF: mis = addr_lo[0];
            default: mis = 1'b0;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/dm_lane_enc.sv
// Combinational byte-lane encoder: turns one access (op, low address, we,
// right-aligned data) into memory byte enables and lane-replicated store data.
module dm_lane_enc
    import dm_port_arbiter_pkg::*;
(
    input  mem_op_e     op_i,
    input  logic [1:0]  addr_lo_i,
    input  logic        we_i,
    input  logic [31:0] wdata_i,
    output logic [3:0]  byteen_o,
    output logic [31:0] lane_data_o,
    output logic        misaligned_o
);

    always_comb begin
        misaligned_o = is_misaligned(op_i, addr_lo_i);
        byteen_o     = 4'b0000;
        lane_data_o  = 32'h0;
        // Loads and rejected accesses leave the write lanes fully idle.
        if (we_i && !misaligned_o) begin
            case (op_i)
                OP_WORD: begin
                    byteen_o    = 4'b1111;
                    lane_data_o = wdata_i;
                end
                OP_BYTE: begin
                    byteen_o    = 4'b0001 << addr_lo_i;
                    lane_data_o = {4{wdata_i[7:0]}};
                end
                OP_HALF: begin
                    byteen_o    = addr_lo_i[1] ? 4'b1100 : 4'b0011;
                    lane_data_o = {2{wdata_i[15:0]}};
                end
                default: begin
                    byteen_o    = 4'b0000;
                    lane_data_o = 32'h0;
                end
            endcase
        end
    end

endmodule

// File: rtl/dm_port_arbiter.sv
// Two-port arbiter for the single synchronous data-memory port: fixed priority
// to the CPU, starvation escape for the DMA/debug loader, one-cycle completion.
module dm_port_arbiter
    import dm_port_arbiter_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  req,
    input  logic [1:0]  we,
    input  logic [1:0]  op0,
    input  logic [1:0]  op1,
    input  logic [31:0] addr0,
    input  logic [31:0] addr1,
    input  logic [31:0] wdata0,
    input  logic [31:0] wdata1,
    output logic [1:0]  gnt,
    output logic [1:0]  ack,
    output logic [1:0]  err,
    output logic [31:0] rdata,
    output logic [31:0] m_data_addr,
    output logic [3:0]  m_data_byteen,
    output logic [31:0] m_data_wdata,
    input  logic [31:0] m_data_rdata
);

    localparam int unsigned CW = $clog2(STARVE_LIMIT + 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          force_p1;
    logic [1:0]    ack_q, err_q;
    logic          rd_valid_q;

    mem_op_e       sel_op;
    logic          sel_we;
    logic [31:0]   sel_addr, sel_wdata;
    logic          granted;
    logic [3:0]    enc_byteen;
    logic [31:0]   enc_data;
    logic          enc_mis;

    assign force_p1 = (cnt_q == CW'(STARVE_LIMIT));

    always_comb begin
        gnt = 2'b00;
        if (force_p1 && req[PORT_DMA])  gnt[PORT_DMA] = 1'b1;
        else if (req[PORT_CPU])         gnt[PORT_CPU] = 1'b1;
        else if (req[PORT_DMA])         gnt[PORT_DMA] = 1'b1;
    end

    assign granted   = |gnt;
    assign sel_op    = gnt[PORT_DMA] ? mem_op_e'(op1) : mem_op_e'(op0);
    assign sel_we    = gnt[PORT_DMA] ? we[PORT_DMA]   : we[PORT_CPU];
    assign sel_addr  = gnt[PORT_DMA] ? addr1  : addr0;
    assign sel_wdata = gnt[PORT_DMA] ? wdata1 : wdata0;

    dm_lane_enc u_lane_enc (
        .op_i         (sel_op),
        .addr_lo_i    (sel_addr[1:0]),
        .we_i         (sel_we),
        .wdata_i      (sel_wdata),
        .byteen_o     (enc_byteen),
        .lane_data_o  (enc_data),
        .misaligned_o (enc_mis)
    );

    // A misaligned grant never reaches memory: address, enables and data stay zero.
    assign m_data_addr   = (granted && !enc_mis) ? {sel_addr[31:2], 2'b00} : 32'h0;
    assign m_data_byteen = granted ? enc_byteen : 4'b0000;
    assign m_data_wdata  = granted ? enc_data   : 32'h0;

    always_comb begin
        cnt_d = cnt_q;
        if (gnt[PORT_DMA] || !req[PORT_DMA]) cnt_d = '0;
        else if (!force_p1)                  cnt_d = cnt_q + CW'(1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q      <= '0;
            ack_q      <= 2'b00;
            err_q      <= 2'b00;
            rd_valid_q <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            ack_q      <= gnt;
            err_q      <= enc_mis ? gnt : 2'b00;
            rd_valid_q <= granted && !sel_we && !enc_mis;
        end
    end

    assign ack = ack_q;
    assign err = err_q;
    // The memory holds its read word in its own output register, valid with the ack.
    assign rdata = rd_valid_q ? m_data_rdata : 32'h0;

endmodule

// File: tb/tb_dm_port_arbiter.sv
// Bench for dm_port_arbiter: directed cases with literal expectations plus
// randomized requesters checked every cycle against a behavioural model.
module tb_dm_port_arbiter;

    localparam int LIMIT = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [1:0]  req = 2'b00, we = 2'b00, op0 = 2'b00, op1 = 2'b00;
    logic [31:0] addr0 = 32'h0, addr1 = 32'h0, wdata0 = 32'h0, wdata1 = 32'h0;
    logic [31:0] m_data_rdata = 32'h0;
    logic [1:0]  gnt, ack, err;
    logic [31:0] rdata, m_data_addr, m_data_wdata;
    logic [3:0]  m_data_byteen;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    dm_port_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
        .clk           (clk),
        .reset         (reset),
        .req           (req),
        .we            (we),
        .op0           (op0),
        .op1           (op1),
        .addr0         (addr0),
        .addr1         (addr1),
        .wdata0        (wdata0),
        .wdata1        (wdata1),
        .gnt           (gnt),
        .ack           (ack),
        .err           (err),
        .rdata         (rdata),
        .m_data_addr   (m_data_addr),
        .m_data_byteen (m_data_byteen),
        .m_data_wdata  (m_data_wdata),
        .m_data_rdata  (m_data_rdata)
    );

    // clock / reset
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    // behavioural model
    function automatic int op_size(input logic [1:0] op);
        case (op)
            2'b00:   return 4;
            2'b01:   return 1;
            2'b10:   return 2;
            default: return 0;
        endcase
    endfunction

    function automatic bit is_aligned(input logic [1:0] op, input logic [31:0] a);
        int sz;
        sz = op_size(op);
        return (sz == 0) || ((int'(a[1:0]) % sz) == 0);
    endfunction

    int         mcnt = 0;
    logic [1:0] m_ack = 2'b00, m_err = 2'b00;
    bit         m_rdv = 1'b0;

    always begin : compare
        logic [1:0]  eg, o;
        logic [31:0] a, wd, ea, ld;
        logic [3:0]  be;
        bit          w, al;
        int          sz;
        @(negedge clk);
        if (mcnt >= LIMIT && req[1]) eg = 2'b10;
        else if (req[0])             eg = 2'b01;
        else if (req[1])             eg = 2'b10;
        else                         eg = 2'b00;
        a  = eg[1] ? addr1 : addr0;
        wd = eg[1] ? wdata1 : wdata0;
        o  = eg[1] ? op1 : op0;
        w  = eg[1] ? we[1] : we[0];
        al = is_aligned(o, a);
        sz = op_size(o);
        be = 4'b0; ea = 32'h0; ld = 32'h0;
        if (eg != 2'b00 && al) begin
            ea = a & 32'hFFFF_FFFC;
            if (w && sz > 0) begin
                be = 4'(((1 << sz) - 1) << a[1:0]);
                for (int i = 0; i < 4; i++) ld[8*i +: 8] = wd[8*(i % sz) +: 8];
            end
        end
        if (chk_en) begin
            chk("model_gnt",    {30'b0, gnt},           {30'b0, eg});
            chk("model_addr",   m_data_addr,            ea);
            chk("model_byteen", {28'b0, m_data_byteen}, {28'b0, be});
            chk("model_wdata",  m_data_wdata,           ld);
            chk("model_ack",    {30'b0, ack},           {30'b0, m_ack});
            chk("model_err",    {30'b0, err},           {30'b0, m_err});
            chk("model_rdata",  rdata,                  m_rdv ? m_data_rdata : 32'h0);
        end
        if (reset) begin
            mcnt = 0; m_ack = 2'b00; m_err = 2'b00; m_rdv = 1'b0;
        end else begin
            m_ack = eg;
            m_err = (eg != 2'b00 && !al) ? eg : 2'b00;
            m_rdv = (eg != 2'b00) && !w && al;
            if (eg[1] || !req[1]) mcnt = 0;
            else if (mcnt < LIMIT) mcnt++;
        end
    end

    // stimulus
    initial begin : main
        logic [1:0] g;
        bit         pend [2];
        logic [1:0] exp_star [6];
        exp_star = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b10, 2'b01};

        reset = 1'b1;
        next(); next();
        reset = 1'b0;
        chk_en = 1'b1;
        @(negedge clk);
        chk("reset_ack",   {30'b0, ack}, 32'h0);
        chk("reset_err",   {30'b0, err}, 32'h0);
        chk("reset_rdata", rdata,        32'h0);

        next();
        req = 2'b01; we = 2'b01; op0 = 2'b00; addr0 = 32'h10; wdata0 = 32'h1234_5678;
        @(negedge clk);
        chk("p0_word_gnt",    {30'b0, gnt},           32'h1);
        chk("p0_word_byteen", {28'b0, m_data_byteen}, 32'hF);
        chk("p0_word_addr",   m_data_addr,            32'h10);
        chk("p0_word_wdata",  m_data_wdata,           32'h1234_5678);
        next();
        req = 2'b00;
        @(negedge clk);
        chk("p0_word_ack", {30'b0, ack}, 32'h1);

        next();
        req = 2'b10; we = 2'b10; op1 = 2'b01; addr1 = 32'h23; wdata1 = 32'hAABB_CCDD;
        @(negedge clk);
        chk("p1_byte_byteen", {28'b0, m_data_byteen}, 32'h8);
        chk("p1_byte_wdata",  m_data_wdata,           32'hDDDD_DDDD);
        chk("p1_byte_addr",   m_data_addr,            32'h20);
        next();
        op1 = 2'b10; addr1 = 32'h22;
        @(negedge clk);
        chk("p1_half_byteen", {28'b0, m_data_byteen}, 32'hC);
        chk("p1_half_wdata",  m_data_wdata,           32'hCCDD_CCDD);
        chk("p1_byte_ack",    {30'b0, ack},           32'h2);
        next();
        req = 2'b00;

        next();
        req = 2'b11; we = 2'b00; op0 = 2'b00; op1 = 2'b00; addr0 = 32'h100; addr1 = 32'h200;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk($sformatf("starve_gnt_%0d", i), {30'b0, gnt}, {30'b0, exp_star[i]});
            next();
        end
        req = 2'b01; we = 2'b00; op0 = 2'b00; addr0 = 32'h8;
        @(negedge clk);
        chk("load_gnt",    {30'b0, gnt},           32'h1);
        chk("load_byteen", {28'b0, m_data_byteen}, 32'h0);
        chk("load_addr",   m_data_addr,            32'h8);
        next();
        m_data_rdata = 32'hCAFE_F00D;
        req = 2'b10; we = 2'b10; op1 = 2'b00; addr1 = 32'h40; wdata1 = 32'h55AA_55AA;
        @(negedge clk);
        chk("load_ack",   {30'b0, ack}, 32'h1);
        chk("load_rdata", rdata,        32'hCAFE_F00D);
        chk("b2b_gnt",    {30'b0, gnt}, 32'h2);
        next();
        req = 2'b00; m_data_rdata = 32'h1111_1111;
        @(negedge clk);
        chk("b2b_ack",   {30'b0, ack}, 32'h2);
        chk("b2b_rdata", rdata,        32'h0);

        next();
        req = 2'b01; we = 2'b01; op0 = 2'b10; addr0 = 32'h5; wdata0 = 32'h0000_BEEF;
        @(negedge clk);
        chk("mis_half_gnt",    {30'b0, gnt},           32'h1);
        chk("mis_half_byteen", {28'b0, m_data_byteen}, 32'h0);
        next();
        req = 2'b10; we = 2'b10; op1 = 2'b00; addr1 = 32'h6;
        @(negedge clk);
        chk("mis_half_ack",    {30'b0, ack},           32'h1);
        chk("mis_half_err",    {30'b0, err},           32'h1);
        chk("mis_word_byteen", {28'b0, m_data_byteen}, 32'h0);
        next();
        req = 2'b00;
        @(negedge clk);
        chk("mis_word_ack", {30'b0, ack}, 32'h2);
        chk("mis_word_err", {30'b0, err}, 32'h2);

        next();
        req = 2'b11; we = 2'b00; op0 = 2'b00; op1 = 2'b00; addr0 = 32'h30; addr1 = 32'h34;
        next(); next();
        reset = 1'b1;
        @(negedge clk);
        chk("rst_grant_gnt", {30'b0, gnt}, 32'h1);
        next();
        reset = 1'b0; m_data_rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        chk("rst_grant_ack",   {30'b0, ack}, 32'h0);
        chk("rst_grant_err",   {30'b0, err}, 32'h0);
        chk("rst_grant_rdata", rdata,        32'h0);
        for (int i = 0; i < 5; i++) begin
            if (i > 0) @(negedge clk);
            chk($sformatf("rst_cnt_gnt_%0d", i), {30'b0, gnt}, {30'b0, exp_star[i]});
            next();
        end
        req = 2'b00;

        pend[0] = 1'b0; pend[1] = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            g = gnt;
            next();
            reset = ($urandom_range(0, 99) == 0);
            m_data_rdata = $urandom;
            for (int p = 0; p < 2; p++) begin
                if (!pend[p] || g[p]) begin
                    pend[p] = (p == 0) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 1) == 1);
                    if (p == 0) begin
                        we[0] = 1'($urandom_range(0, 1)); op0 = 2'($urandom_range(0, 3));
                        addr0 = $urandom & 32'h0000_0FFF; wdata0 = $urandom;
                    end else begin
                        we[1] = 1'($urandom_range(0, 1)); op1 = 2'($urandom_range(0, 3));
                        addr1 = $urandom & 32'h0000_0FFF; wdata1 = $urandom;
                    end
                end else if (p == 1 && $urandom_range(0, 15) == 0) begin
                    pend[p] = 1'b0;
                end
            end
            req = {pend[1], pend[0]};
        end
        req = 2'b00; reset = 1'b0;
        next(); next();
        @(negedge clk);
        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/dm_port_arbiter.md
# dm_port_arbiter

Shares the single synchronous data-memory port between two requesters: the CPU MEM stage (port 0) and the DMA/debug loader (port 1). Each cycle it grants at most one request, drives byte-lane enables and lane-aligned write data toward memory, and returns a registered completion with read data one cycle later. Port 0 has fixed priority, and a starvation counter guarantees port 1 forward progress. Misaligned accesses are rejected without touching memory.

## Interface
Parameters:
- STARVE_LIMIT, 4: consecutive denied port-1 request cycles before port 1 is forced to win (≥1).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- req  in  2  request per port; must hold stable, with its payload, until granted
- we  in  2  1 = store, 0 = load, per port
- op0, op1  in  2 each  size: 00 word, 01 byte, 10 half, 11 none
- addr0, addr1  in  32 each  byte address
- wdata0, wdata1  in  32 each  store data, right-aligned
- gnt  out  2  one-hot or zero, combinational, same cycle as req
- ack  out  2  registered; one-cycle pulse on port g in cycle N+1 for a grant in cycle N
- err  out  2  registered; pulses together with ack when the granted access was misaligned
- rdata  out  32  registered raw memory word for the acked load; 0 otherwise
- m_data_addr  out  32  word address: granted addr with [1:0] forced to 00; 0 when idle
- m_data_byteen  out  4  byte write enables; 0000 for loads, op none, errors, idle
- m_data_wdata  out  32  lane-aligned store data; 0 when byteen is 0000
- m_data_rdata  in  32  memory read data, valid the cycle after the address

## Operation
- Grant rule: if force_p1 && req[1], then port 1; else if req[0], then port 0; else if req[1], then port 1; else none.
- Starvation: cnt increments in each cycle with req[1] && !gnt[1]. When cnt reaches STARVE_LIMIT, force_p1 is set and cnt saturates. On gnt[1], cnt and force_p1 clear. When req[1] drops, cnt clears.
- Alignment: word requires addr[1:0]=00 and half requires addr[0]=0. Byte and none are always aligned. A misaligned grant is still granted and acked, but memory outputs are idle (byteen 0000), and err plus ack pulse next cycle.
- Lane encoding for stores:
  - Word: byteen 1111, data = wdata.
  - Byte: byteen is the single bit addr[1:0], and wdata[7:0] is replicated into all four lanes.
  - Half: byteen is 0011 or 1100 by addr[1], and wdata[15:0] is replicated into both halves.
  - None: byteen 0000.
- Only bytes whose byteen bit is set carry meaning. The outside of the enabled lanes must still be exactly the replicated value, for checking.
- Loads: byteen 0000, address driven. Next cycle rdata = m_data_rdata. Sign and zero extension belong to the load path, not this block.
- One access per cycle, fully pipelined, with no internal busy state beyond the response register.

## Timing
- Reset: ack=00, err=00, rdata=0, cnt=0, force_p1=0. Combinational outputs follow the rule with force_p1=0.
- Grant latency: 0 cycles. Completion latency: exactly 1 cycle (ack in N+1). Back-to-back grants in N and N+1 produce acks in N+1 and N+2.
- Reset asserted in cycle N: no ack in N+1, even if a grant occurred in N. The memory write in N still happens; memory is outside the reset domain.
- Simultaneous req on both ports with force_p1=0 gives port 0, and the port-1 counter advances.
- A requester that drops req before grant is dropped silently.

## Structure
- Shared package: op encodings (OP_WORD, OP_BYTE, OP_HALF, OP_NONE) and port indices, reused by the MEM stage and the load extender.
- One sub-module, dm_lane_enc. It is combinational: (op, addr[1:0], we, wdata) produces (byteen, lane data, misaligned). The arbiter muxes the granted port's fields into a single instance.

## Test plan
- Port 0 store word: addr 0x0000_0010, wdata 0x1234_5678 → gnt=01, byteen 1111, m_data_addr 0x10, wdata 0x12345678, then ack=01 next cycle.
- Port 1 store byte: addr 0x0000_0023, wdata 0xAABB_CCDD → byteen 1000, m_data_wdata 0xDDDDDDDD, m_data_addr 0x20. Same for half at 0x22 → byteen 1100, data 0xCCDDCCDD.
- Both ports request every cycle with STARVE_LIMIT=4 → port 0 wins 4 cycles, port 1 wins in the 5th, cnt returns to 0, and port 0 wins again.
- Port 0 load at 0x8 with memory returning 0xCAFEF00D → byteen 0000 in N, rdata 0xCAFEF00D with ack=01 in N+1. A port-1 store granted in N+1 acks in N+2.
- Misaligned half at 0x0000_0005 on port 0 → gnt=01, byteen 0000, then ack=01 and err=01 next cycle. A word at 0x6 on port 1 behaves the same.
- Reset asserted in the cycle of a grant → ack, err, and rdata are 0 the following cycle. cnt and force_p1 clear.
